// File: rtl/fpu_pkg.sv
// rtl/fpu_pkg.sv - shared defaults, state encoding and seed helper for the float unit
package fpu_pkg;

  localparam int NSIG_DEF   = 7;
  localparam int GUARD_DEF  = 4;
  localparam int NITER_DEF  = 2;
  localparam int SEED_IDX_W = 3;
  localparam int ITER_W     = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MUL_AX = 2'd1,
    MUL_XD = 2'd2,
    DONE   = 2'd3
  } recip_state_e;

  // Rounded reciprocal of the midpoint of seed interval idx, Q1.f:
  // round(2^(f+4) / (16 + 2*idx + 1)) done as an integer round-half-up.
  function automatic int recip_seed(input int idx, input int f);
    int den;
    den = 16 + 2 * idx + 1;
    return ((1 << (f + 5)) + den) / (2 * den);
  endfunction

endpackage

// File: rtl/recip_seed_rom.sv
// rtl/recip_seed_rom.sv - 8-entry reciprocal seed lookup, index -> Q1.F
module recip_seed_rom
  import fpu_pkg::*;
#(
  parameter int NSIG  = NSIG_DEF,
  parameter int GUARD = GUARD_DEF
) (
  input  logic [SEED_IDX_W-1:0]   idx,
  output logic [NSIG+GUARD:0]     seed
);

  localparam int F       = NSIG + GUARD;
  localparam int W       = F + 1;
  localparam int ENTRIES = 1 << SEED_IDX_W;

  logic [W-1:0] rom [ENTRIES];

  for (genvar i = 0; i < ENTRIES; i++) begin : g_rom
    assign rom[i] = W'(recip_seed(i, F));
  end

  assign seed = rom[idx];

endmodule

// File: rtl/recip_nr_sequencer.sv
// rtl/recip_nr_sequencer.sv - Newton-Raphson reciprocal sequencer with one shared multiplier
module recip_nr_sequencer
  import fpu_pkg::*;
#(
  parameter int NSIG  = NSIG_DEF,
  parameter int GUARD = GUARD_DEF,
  parameter int NITER = NITER_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [NSIG:0]   in_a,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [NSIG:0]   out_r,
  output logic            out_err
);

  localparam int F = NSIG + GUARD;
  localparam int W = F + 1;
  localparam logic [F+1:0] TWO = (F + 2)'(1) << (F + 1);

  recip_state_e      state;
  logic [W-1:0]      a_q;
  logic [W-1:0]      x_q;
  logic [W-1:0]      d_q;
  logic [ITER_W-1:0] iter_cnt;

  logic [W-1:0]      seed;
  logic [W-1:0]      mul_a;
  logic [W-1:0]      mul_b;
  logic [2*W-1:0]    prod;
  logic [F+1:0]      prod_hi;
  logic [W-1:0]      d_next;
  logic [W-1:0]      x_next;

  recip_seed_rom #(
    .NSIG  (NSIG),
    .GUARD (GUARD)
  ) u_seed_rom (
    .idx  (in_a[NSIG-1:NSIG-SEED_IDX_W]),
    .seed (seed)
  );

  // Single multiplier: (A, x) forms the error term, (x, d) refines the estimate.
  always_comb begin
    mul_a = x_q;
    mul_b = d_q;
    if (state == MUL_AX) begin
      mul_a = a_q;
      mul_b = x_q;
    end
  end

  assign prod    = (2 * W)'(mul_a) * (2 * W)'(mul_b);
  assign prod_hi = (F + 2)'(prod >> F);
  assign d_next  = W'(TWO - prod_hi);
  assign x_next  = W'(prod >> F);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_r     <= '0;
      out_err   <= 1'b0;
      iter_cnt  <= '0;
      a_q       <= '0;
      x_q       <= '0;
      d_q       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            in_ready <= 1'b0;
            a_q      <= W'({in_a, {GUARD{1'b0}}});
            if (!in_a[NSIG]) begin
              out_r     <= '0;
              out_err   <= 1'b1;
              out_valid <= 1'b1;
              state     <= DONE;
            end else if (in_a[NSIG-1:0] == '0) begin
              out_r     <= {1'b1, {NSIG{1'b0}}};
              out_err   <= 1'b0;
              out_valid <= 1'b1;
              state     <= DONE;
            end else begin
              x_q      <= seed;
              iter_cnt <= '0;
              state    <= MUL_AX;
            end
          end
        end
        MUL_AX: begin
          d_q   <= d_next;
          state <= MUL_XD;
        end
        MUL_XD: begin
          x_q <= x_next;
          if (iter_cnt == ITER_W'(NITER - 1)) begin
            out_r     <= (NSIG + 1)'(x_next >> GUARD);
            out_err   <= 1'b0;
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            iter_cnt <= iter_cnt + 1'b1;
            state    <= MUL_AX;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_recip_nr_sequencer.sv
// tb/tb_recip_nr_sequencer.sv - self-checking bench for recip_nr_sequencer
module tb_recip_nr_sequencer;

  localparam int NSIG  = 7;
  localparam int GUARD = 4;
  localparam int NITER = 2;
  localparam int F     = NSIG + GUARD;
  localparam int MASK  = (1 << (F + 1)) - 1;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_a;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_r;
  logic       out_err;

  int checks = 0;
  int errors = 0;

  recip_nr_sequencer #(
    .NSIG  (NSIG),
    .GUARD (GUARD),
    .NITER (NITER)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_r     (out_r),
    .out_err   (out_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Reference: {err, r} from plain integer Newton-Raphson with a real-valued seed.
  function automatic logic [8:0] model_recip(input logic [7:0] a);
    int ai, x, d, p, idx;
    logic [7:0] r;
    if (!a[7]) return {1'b1, 8'h00};
    if (a[6:0] == 7'd0) return {1'b0, 8'h80};
    ai  = int'(a) << GUARD;
    idx = int'(a[6:4]);
    x   = $rtoi(real'(1 << F) / (1.0 + (2.0 * idx + 1.0) / 16.0) + 0.5);
    for (int k = 0; k < NITER; k++) begin
      p = (ai * x) >>> F;
      d = ((2 << F) - p) & MASK;
      x = ((x * d) >>> F) & MASK;
    end
    r = 8'(x >> GUARD);
    return {1'b0, r};
  endfunction

  function automatic int model_lat(input logic [7:0] a);
    if (!a[7] || a[6:0] == 7'd0) return 1;
    return 2 * NITER + 1;
  endfunction

  // Cycle-level expectation: idle / busy countdown / done-holding.
  bit         m_started = 1'b0;
  bit         m_idle    = 1'b1;
  bit         m_done    = 1'b0;
  int         m_wait    = 0;
  logic [7:0] m_r       = 8'h00;
  bit         m_err     = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_started <= 1'b1;
      m_idle    <= 1'b1;
      m_done    <= 1'b0;
      m_wait    <= 0;
    end else if (m_idle) begin
      if (in_valid) begin
        m_idle <= 1'b0;
        m_r    <= model_recip(in_a)[7:0];
        m_err  <= model_recip(in_a)[8];
        m_wait <= model_lat(in_a) - 1;
        m_done <= (model_lat(in_a) == 1);
      end
    end else if (m_done) begin
      if (out_ready) begin
        m_done <= 1'b0;
        m_idle <= 1'b1;
      end
    end else begin
      if (m_wait == 1) m_done <= 1'b1;
      m_wait <= m_wait - 1;
    end
  end

  always @(negedge clk) begin
    if (m_started) begin
      chk("mon_in_ready", int'(in_ready), int'(m_idle));
      chk("mon_out_valid", int'(out_valid), int'(m_done));
      if (m_done) begin
        chk("mon_out_r", int'(out_r), int'(m_r));
        chk("mon_out_err", int'(out_err), int'(m_err));
      end
    end
  end

  task automatic send(input logic [7:0] a);
    int n;
    n = 0;
    in_a     = a;
    in_valid = 1'b1;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("send_timeout", 0, 1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_result(input int exp_lat, output logic [7:0] r, output logic e);
    int c;
    c = 1;
    while (!out_valid && c < 40) begin
      chk("busy_in_ready", int'(in_ready), 0);
      @(negedge clk);
      c++;
    end
    chk("latency", c, exp_lat);
    r = out_r;
    e = out_err;
  endtask

  task automatic run_op(input logic [7:0] a, output logic [7:0] r, output logic e);
    send(a);
    wait_result(model_lat(a), r, e);
    if (out_ready) @(negedge clk);
  endtask

  logic [7:0] r, r0;
  logic       e;
  int         diff;

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_a      = 8'h00;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_in_ready", int'(in_ready), 1);
    chk("reset_out_valid", int'(out_valid), 0);
    chk("reset_out_r", int'(out_r), 0);
    chk("reset_out_err", int'(out_err), 0);

    chk("model_c0", int'(model_recip(8'hC0)), 9'h055);
    chk("model_a0", int'(model_recip(8'hA0)), 9'h066);
    chk("model_e0", int'(model_recip(8'hE0)), 9'h049);
    chk("model_ff", int'(model_recip(8'hFF)), 9'h040);
    chk("model_80", int'(model_recip(8'h80)), 9'h080);
    chk("model_40", int'(model_recip(8'h40)), 9'h100);

    run_op(8'hC0, r, e);
    chk("c0_in_range", int'(r == 8'h55 || r == 8'h56), 1);
    chk("c0_err", int'(e), 0);

    run_op(8'h80, r, e);
    chk("bypass_r", int'(r), 8'h80);
    chk("bypass_err", int'(e), 0);

    run_op(8'h40, r, e);
    chk("unnorm_r", int'(r), 8'h00);
    chk("unnorm_err", int'(e), 1);

    for (int a = 8'h81; a <= 8'hFF; a++) begin
      run_op(8'(a), r, e);
      chk("sweep_model", int'({e, r}), int'(model_recip(8'(a))));
      diff = int'(r) * a - 16384;
      if (diff < 0) diff = -diff;
      chk("sweep_ulp", int'(diff < a), 1);
      if (a == 8'hFF) chk("ff_in_range", int'(r == 8'h40 || r == 8'h41), 1);
    end

    out_ready = 1'b0;
    send(8'hA0);
    wait_result(2 * NITER + 1, r0, e);
    chk("bp_in_range", int'(r0 == 8'h66 || r0 == 8'h67), 1);
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      in_a     = 8'h55;
      @(negedge clk);
      chk("bp_hold_valid", int'(out_valid), 1);
      chk("bp_hold_r", int'(out_r), int'(r0));
      chk("bp_hold_in_ready", int'(in_ready), 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_in_ready", int'(in_ready), 1);
    chk("bp_release_valid", int'(out_valid), 0);

    send(8'hC0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_out_valid", int'(out_valid), 0);
    chk("abort_in_ready", int'(in_ready), 1);
    rst = 1'b0;
    @(negedge clk);
    run_op(8'hE0, r, e);
    chk("post_abort_in_range", int'(r == 8'h49 || r == 8'h4A), 1);
    chk("post_abort_model", int'({e, r}), int'(model_recip(8'hE0)));

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
